// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM encoding and statistics width.
// Used by dmem_arbiter and its rr_pick priority encoder.
package dmem_arb_pkg;

  localparam int ST_W   = 2;
  localparam int STAT_W = 16;

  typedef enum logic [ST_W-1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Saturating increment for the per-core grant counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: picks the first set bit of eff searching upward from ptr+1 with wrap.
// Purely combinational; the caller registers the result.
module rr_pick #(
  parameter int N_CORES = 4,
  parameter int IDX_W   = 2
) (
  input  logic [N_CORES-1:0] eff,
  input  logic [IDX_W-1:0]   ptr,
  output logic [N_CORES-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  int best_d;

  // Distance of core i from the slot just after ptr, in rotation order.
  function automatic int dist_of(input int i, input int p);
    return (i + N_CORES - 1 - p) % N_CORES;
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    onehot = '0;
    idx    = '0;
    best_d = N_CORES;
    for (int i = 0; i < N_CORES; i++) begin
      if (eff[i] && dist_of(i, int'(ptr)) < best_d) begin
        best_d    = dist_of(i, int'(ptr));
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter serialising single-word core accesses onto one synchronous data memory.
// Optional per-core grant counters are enabled with the ARB_STATS_EN macro.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CORES-1:0]        core_en,
  input  logic [N_CORES-1:0]        core_req,
  input  logic [N_CORES-1:0]        core_we,
  input  logic [N_CORES*ADDR_W-1:0] core_addr,
  input  logic [N_CORES*DATA_W-1:0] core_wdata,
  output logic [N_CORES-1:0]        core_gnt,
  output logic [N_CORES-1:0]        core_rvalid,
  output logic [DATA_W-1:0]         core_rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
`ifdef ARB_STATS_EN
  ,
  output logic [N_CORES*STAT_W-1:0] grant_cnt
`endif
);

  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [N_CORES-1:0]  eff;
  logic [N_CORES-1:0]  pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic [N_CORES-1:0]  win_oh;
  logic                win_we;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  assign eff = core_req & core_en;

  rr_pick #(.N_CORES(N_CORES), .IDX_W(IDX_W)) u_pick (
    .eff    (eff),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  // One-hot AND-OR mux of the candidate winner's request fields.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (pick_oh[i]) begin
        sel_we    = sel_we    | core_we[i];
        sel_addr  = sel_addr  | core_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = sel_wdata | core_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= IDX_W'(N_CORES - 1);
      win_oh      <= '0;
      win_we      <= 1'b0;
      core_gnt    <= '0;
      core_rvalid <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      // NOTE: state and registered outputs use <= so every branch sees pre-edge values.
      core_gnt    <= '0;
      core_rvalid <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      case (state)
        IDLE: begin
          if (|eff) begin
            state     <= ACCESS;
            ptr       <= pick_idx;
            win_oh    <= pick_oh;
            win_we    <= sel_we;
            core_gnt  <= pick_oh;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
          end
        end
        ACCESS: begin
          state <= win_we ? IDLE : RESP;
          if (!win_we) core_rvalid <= win_oh;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read data arrives from memory during RESP, so it is passed through rather than registered.
  assign core_rdata = (state == RESP) ? mem_rdata : '0;
  assign busy       = (state != IDLE);

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] cnt [N_CORES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the counter array is a handful of flops, not a RAM, so it takes the reset.
      for (int i = 0; i < N_CORES; i++) cnt[i] <= '0;
    end else if (state == ACCESS) begin
      for (int i = 0; i < N_CORES; i++)
        if (win_oh[i]) cnt[i] <= sat_inc(cnt[i]);
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_CORES; i++) grant_cnt[i*STAT_W +: STAT_W] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table for single-cycle behaviour plus
// hand-written reset, contention and (with ARB_STATS_EN) counter sequences.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  core_en, core_req, core_we;
  logic [47:0] core_addr;
  logic [63:0] core_wdata;
  logic [3:0]  core_gnt, core_rvalid;
  logic [15:0] core_rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        busy;
`ifdef ARB_STATS_EN
  logic [63:0] grant_cnt;
`endif

  dmem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .core_en     (core_en),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_gnt    (core_gnt),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
`ifdef ARB_STATS_EN
    ,
    .grant_cnt   (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory attached to the arbiter.
  logic [15:0] mem [4096];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic [3:0]  en, req, we;
    logic [3:0]  gnt, rv;
    logic        men, mwe;
    logic [11:0] addr;
    logic [15:0] wd, rd;
    logic        busy;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] en, req, we, gnt, rv, input logic men, mwe,
                     input logic [11:0] addr, input logic [15:0] wd, rd, input logic b);
    vecs.push_back('{en, req, we, gnt, rv, men, mwe, addr, wd, rd, b});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " gnt"},    32'(core_gnt),    32'h0);
    check({tag, " rvalid"}, 32'(core_rvalid), 32'h0);
    check({tag, " mem_en"}, 32'(mem_en),      32'h0);
    check({tag, " mem_we"}, 32'(mem_we),      32'h0);
    check({tag, " addr"},   32'(mem_addr),    32'h0);
    check({tag, " wdata"},  32'(mem_wdata),   32'h0);
    check({tag, " rdata"},  32'(core_rdata),  32'h0);
    check({tag, " busy"},   32'(busy),        32'h0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h000] = 16'h1234;
    mem[12'h010] = 16'h00AB;
    mem_rdata  = 16'h0000;
    rst_n      = 1'b0;
    core_en    = 4'hF;
    core_req   = 4'h0;
    core_we    = 4'h0;
    core_addr  = {12'h030, 12'h020, 12'h010, 12'h000};
    core_wdata = {16'hD003, 16'hD002, 16'hD001, 16'hD000};

    // Table: en, req, we | gnt, rvalid, mem_en, mem_we, addr, wdata, rdata, busy
    add(4'hF, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1, 0, 12'h010, 16'hD001, 16'h0000, 1);
    add(4'hF, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0, 0, 12'h000, 16'h0000, 16'h00AB, 1);
    add(4'hF, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 12'h000, 16'h0000, 16'h0000, 0);
    add(4'h7, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 0, 0, 12'h000, 16'h0000, 16'h0000, 0);
    add(4'h7, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 0, 0, 12'h000, 16'h0000, 16'h0000, 0);
    add(4'hF, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 1, 1, 12'h020, 16'hD002, 16'h0000, 1);
    add(4'hF, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 12'h000, 16'h0000, 16'h0000, 0);
    add(4'hF, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1, 0, 12'h020, 16'hD002, 16'h0000, 1);
    add(4'h3, 4'b1100, 4'b0000, 4'b0000, 4'b0100, 0, 0, 12'h000, 16'h0000, 16'hD002, 1);
    add(4'h3, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0, 12'h000, 16'h0000, 16'h0000, 0);
    add(4'h3, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 1, 0, 12'h000, 16'hD000, 16'h0000, 1);
    add(4'h3, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 0, 12'h000, 16'h0000, 16'h1234, 1);
    add(4'h3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 12'h000, 16'h0000, 16'h0000, 0);
    add(4'hF, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1, 0, 12'h010, 16'hD001, 16'h0000, 1);
    add(4'hF, 4'b1000, 4'b1000, 4'b0000, 4'b0010, 0, 0, 12'h000, 16'h0000, 16'h00AB, 1);
    add(4'hF, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 12'h000, 16'h0000, 16'h0000, 0);
    add(4'hF, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 12'h000, 16'h0000, 16'h0000, 0);

    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      core_en  = vecs[i].en;
      core_req = vecs[i].req;
      core_we  = vecs[i].we;
      @(posedge clk);
      #1;
      check($sformatf("v%0d gnt", i),    32'(core_gnt),    32'(vecs[i].gnt));
      check($sformatf("v%0d rvalid", i), 32'(core_rvalid), 32'(vecs[i].rv));
      check($sformatf("v%0d mem_en", i), 32'(mem_en),      32'(vecs[i].men));
      check($sformatf("v%0d mem_we", i), 32'(mem_we),      32'(vecs[i].mwe));
      check($sformatf("v%0d addr", i),   32'(mem_addr),    32'(vecs[i].addr));
      check($sformatf("v%0d wdata", i),  32'(mem_wdata),   32'(vecs[i].wd));
      check($sformatf("v%0d rdata", i),  32'(core_rdata),  32'(vecs[i].rd));
      check($sformatf("v%0d busy", i),   32'(busy),        32'(vecs[i].busy));
    end

    // Reset while core 2's read is in ACCESS: outputs clear without waiting for a clock.
    core_en  = 4'hF;
    core_req = 4'b0100;
    core_we  = 4'b0000;
    @(posedge clk);
    #1;
    check("pre-reset gnt",    32'(core_gnt), 32'h4);
    check("pre-reset mem_en", 32'(mem_en),   32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("async reset");
    core_req = 4'hF;
    core_we  = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // All four cores write continuously: rotation starts at core 0 after reset.
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("rot%0d gnt", k),    32'(core_gnt),    32'(4'b0001 << (k % 4)));
      check($sformatf("rot%0d rvalid", k), 32'(core_rvalid), 32'h0);
      check($sformatf("rot%0d mem_we", k), 32'(mem_we),      32'h1);
      check($sformatf("rot%0d addr", k),   32'(mem_addr),    32'((k % 4) * 16));
      @(posedge clk);
      #1;
      check($sformatf("rot%0d gap gnt", k),  32'(core_gnt), 32'h0);
      check($sformatf("rot%0d gap busy", k), 32'(busy),     32'h0);
    end
    core_req = 4'h0;
    core_we  = 4'h0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      check($sformatf("mem[%0h]", i * 16), 32'(mem[12'(i * 16)]), 32'(16'hD000 + i));

`ifdef ARB_STATS_EN
    rst_n = 1'b0;
    #1;
    check("stats reset", 32'(grant_cnt[31:0]), 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    core_req = 4'b0001;
    core_we  = 4'b0001;
    repeat (10) @(posedge clk);
    #1;
    core_req = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("stats core0", 32'(grant_cnt[15:0]),  32'd5);
    check("stats core1", 32'(grant_cnt[31:16]), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
